// File: rtl/input_debounce_if.sv
// Signal bundle between the debounce block and the MCU GPIO/interrupt logic.
// The slave modport is the debounce block; the master modport is its user.
interface input_debounce_if #(
   parameter int N_CH = 8
);
   logic [N_CH-1:0] RAW_IN;
   logic [N_CH-1:0] DB_OUT;
   logic [N_CH-1:0] RISE_PULSE;
   logic [N_CH-1:0] FALL_PULSE;
   logic [N_CH-1:0] EVT_PEND;
   logic [N_CH-1:0] EVT_CLR;
   logic            IRQ;

   modport master (
      output RAW_IN, EVT_CLR,
      input  DB_OUT, RISE_PULSE, FALL_PULSE, EVT_PEND, IRQ
   );

   modport slave (
      input  RAW_IN, EVT_CLR,
      output DB_OUT, RISE_PULSE, FALL_PULSE, EVT_PEND, IRQ
   );
endinterface

// File: rtl/input_debounce.sv
// Per-channel synchroniser + stability-counter debouncer for buttons/switches,
// with registered edge pulses, sticky W1C event flags and a combined IRQ.
module input_debounce #(
   parameter int N_CH            = 8,
   parameter int CNT_W           = 20,
   parameter int DEBOUNCE_CYCLES = 400000,
   parameter int EVT_EDGE        = 2
) (
   input logic           CLKIN,
   input logic           nSRSTIN,
   input_debounce_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [N_CH-1:0]  RISE_MASK = (EVT_EDGE != 1) ? {N_CH{1'b1}} : {N_CH{1'b0}};
   localparam logic [N_CH-1:0]  FALL_MASK = (EVT_EDGE != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

   logic [N_CH-1:0]  sync1_q;
   logic [N_CH-1:0]  sync2_q;
   logic [N_CH-1:0]  db_q,   db_d;
   logic [N_CH-1:0]  rise_q, rise_d;
   logic [N_CH-1:0]  fall_q, fall_d;
   logic [N_CH-1:0]  pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];

   // Counter only advances while the synchronised level disagrees with the
   // accepted level; any agreement discards progress.
   always_comb begin
      db_d   = db_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               db_d[i]   = sync2_q[i];
               rise_d[i] = sync2_q[i];
               fall_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      // A new event wins over a same-cycle clear so no event is lost.
      pend_d = (rise_d & RISE_MASK) | (fall_d & FALL_MASK) | (pend_q & ~bus.EVT_CLR);
   end

   always_ff @(posedge CLKIN or negedge nSRSTIN) begin
      if (!nSRSTIN) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         pend_q  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= bus.RAW_IN;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         pend_q  <= pend_d;
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.DB_OUT     = db_q;
   assign bus.RISE_PULSE = rise_q;
   assign bus.FALL_PULSE = fall_q;
   assign bus.EVT_PEND   = pend_q;
   assign bus.IRQ        = |pend_q;
endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: two instances (both-edge and rise-only events) driven
// by shared stimulus and compared against a sliding-window reference model.
module tb_input_debounce;
   localparam int N_CH  = 8;
   localparam int CNT_W = 20;
   localparam int DB    = 4;

   logic       CLKIN   = 1'b0;
   logic       nSRSTIN = 1'b0;
   logic [7:0] raw_drv = '0;
   logic [7:0] clr_drv = '0;
   int         chk_cnt  = 0;
   int         fail_cnt = 0;

   input_debounce_if #(.N_CH(N_CH)) bus_b ();
   input_debounce_if #(.N_CH(N_CH)) bus_r ();

   assign bus_b.RAW_IN  = raw_drv;
   assign bus_b.EVT_CLR = clr_drv;
   assign bus_r.RAW_IN  = raw_drv;
   assign bus_r.EVT_CLR = clr_drv;

   input_debounce #(.N_CH(N_CH), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DB), .EVT_EDGE(2)) dut_b (
      .CLKIN(CLKIN), .nSRSTIN(nSRSTIN), .bus(bus_b)
   );
   input_debounce #(.N_CH(N_CH), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DB), .EVT_EDGE(0)) dut_r (
      .CLKIN(CLKIN), .nSRSTIN(nSRSTIN), .bus(bus_r)
   );

   // ---------------- clock ----------------
   always #5 CLKIN = ~CLKIN;

   // ---------------- reference model ----------------
   // A level is accepted once it has been seen on the pad for DB consecutive
   // samples (ending two samples ago, to cover the synchroniser).
   logic [7:0] hist[$];
   logic [7:0] m_db, m_rise, m_fall, m_pend_b, m_pend_r;
   logic [49:0] dut_vec, mdl_vec;

   assign dut_vec = {bus_b.DB_OUT, bus_b.RISE_PULSE, bus_b.FALL_PULSE, bus_b.EVT_PEND, bus_b.IRQ,
                     bus_r.DB_OUT, bus_r.EVT_PEND, bus_r.IRQ};
   assign mdl_vec = {m_db, m_rise, m_fall, m_pend_b, |m_pend_b, m_db, m_pend_r, |m_pend_r};

   task automatic model_reset();
      m_db = '0; m_rise = '0; m_fall = '0; m_pend_b = '0; m_pend_r = '0;
      hist.delete();
      for (int i = 0; i < DB + 1; i++) hist.push_back(8'h00);
   endtask

   task automatic tick();
      logic [7:0] s_clr;
      logic       v, stable;
      int         sz;
      @(posedge CLKIN);
      s_clr = clr_drv;
      if (hist.size() > DB + 1) void'(hist.pop_front());
      hist.push_back(raw_drv);
      sz = hist.size();
      m_rise = '0;
      m_fall = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         v = hist[sz-3][ch];
         stable = 1'b1;
         for (int j = sz - 2 - DB; j <= sz - 3; j++) if (hist[j][ch] != v) stable = 1'b0;
         if (stable && (v != m_db[ch])) begin
            m_db[ch] = v;
            if (v) m_rise[ch] = 1'b1;
            else   m_fall[ch] = 1'b1;
         end
      end
      m_pend_b = m_rise | m_fall | (m_pend_b & ~s_clr);
      m_pend_r = m_rise | (m_pend_r & ~s_clr);
      @(negedge CLKIN);
   endtask

   task automatic restart(input logic [7:0] raw);
      nSRSTIN = 1'b0;
      raw_drv = raw;
      clr_drv = '0;
      @(negedge CLKIN);
      @(negedge CLKIN);
      model_reset();
      nSRSTIN = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      nSRSTIN = 1'b0;
      raw_drv = 8'hFF;
      clr_drv = '0;
      #3;
      chk_cnt++;
      if (dut_vec !== 50'h0) begin
         fail_cnt++;
         $display("FAIL reset_hold got=%h expected=%h", dut_vec, 50'h0);
      end
      @(negedge CLKIN);
      model_reset();
      nSRSTIN = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         chk_cnt++;
         if (dut_vec !== mdl_vec) begin
            fail_cnt++;
            $display("FAIL reset_model n=%0d got=%h expected=%h", n, dut_vec, mdl_vec);
         end
         chk_cnt++;
         if ({bus_b.DB_OUT, bus_b.RISE_PULSE, bus_b.IRQ} !==
             {(n >= 6) ? 8'hFF : 8'h00, (n == 6) ? 8'hFF : 8'h00, (n >= 6)}) begin
            fail_cnt++;
            $display("FAIL reset_release n=%0d got db=%h rise=%h irq=%b", n,
                     bus_b.DB_OUT, bus_b.RISE_PULSE, bus_b.IRQ);
         end
      end
   endtask

   task automatic test_clean_press();
      int rises = 0;
      restart(8'h00);
      tick(); tick();
      raw_drv[0] = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         rises += int'(bus_b.RISE_PULSE[0]);
         chk_cnt++;
         if (dut_vec !== mdl_vec) begin
            fail_cnt++;
            $display("FAIL press_model n=%0d got=%h expected=%h", n, dut_vec, mdl_vec);
         end
         chk_cnt++;
         if ({bus_b.DB_OUT[0], bus_b.EVT_PEND} !== {n >= 6, (n >= 6) ? 8'h01 : 8'h00}) begin
            fail_cnt++;
            $display("FAIL press_db n=%0d got db0=%b pend=%h", n, bus_b.DB_OUT[0], bus_b.EVT_PEND);
         end
      end
      chk_cnt++;
      if (rises !== 1) begin
         fail_cnt++;
         $display("FAIL press_rise_count got=%0d expected=1", rises);
      end
      raw_drv[0] = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         tick();
         chk_cnt++;
         if ({bus_b.FALL_PULSE[0], bus_b.DB_OUT[0]} !== {n == 6, n < 6}) begin
            fail_cnt++;
            $display("FAIL release_fall n=%0d got fall0=%b db0=%b", n, bus_b.FALL_PULSE[0], bus_b.DB_OUT[0]);
         end
      end
   endtask

   task automatic test_bounce();
      restart(8'h00);
      for (int idx = 0; idx < 12; idx++) begin
         raw_drv[2] = (idx == 3) ? 1'b0 : 1'b1;
         tick();
         chk_cnt++;
         if (dut_vec !== mdl_vec) begin
            fail_cnt++;
            $display("FAIL bounce_model idx=%0d got=%h expected=%h", idx, dut_vec, mdl_vec);
         end
         chk_cnt++;
         if ({bus_b.DB_OUT[2], bus_b.RISE_PULSE[2], bus_b.FALL_PULSE[2]} !== {idx >= 9, idx == 9, 1'b0}) begin
            fail_cnt++;
            $display("FAIL bounce_db idx=%0d got db2=%b rise2=%b fall2=%b", idx,
                     bus_b.DB_OUT[2], bus_b.RISE_PULSE[2], bus_b.FALL_PULSE[2]);
         end
      end
   endtask

   task automatic test_clear_race();
      restart(8'h00);
      raw_drv[1] = 1'b1;
      for (int n = 1; n <= 5; n++) tick();
      clr_drv[1] = 1'b1;
      tick();
      chk_cnt++;
      if ({bus_b.RISE_PULSE[1], bus_b.EVT_PEND[1], bus_b.IRQ} !== 3'b111) begin
         fail_cnt++;
         $display("FAIL clear_race_set got rise1=%b pend1=%b irq=%b expected 1 1 1",
                  bus_b.RISE_PULSE[1], bus_b.EVT_PEND[1], bus_b.IRQ);
      end
      tick();
      chk_cnt++;
      if ({bus_b.EVT_PEND, bus_b.IRQ, dut_vec} !== {8'h00, 1'b0, mdl_vec}) begin
         fail_cnt++;
         $display("FAIL clear_race_clr got pend=%h irq=%b vec=%h expected vec=%h",
                  bus_b.EVT_PEND, bus_b.IRQ, dut_vec, mdl_vec);
      end
      clr_drv = '0;
   endtask

   task automatic test_rise_only();
      restart(8'h00);
      raw_drv[5] = 1'b1;
      for (int n = 1; n <= 8; n++) tick();
      chk_cnt++;
      if ({bus_r.EVT_PEND, bus_r.IRQ} !== {8'h20, 1'b1}) begin
         fail_cnt++;
         $display("FAIL rise_only_set got pend=%h irq=%b expected 20 1", bus_r.EVT_PEND, bus_r.IRQ);
      end
      clr_drv = 8'h20;
      tick();
      clr_drv = '0;
      raw_drv[5] = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         chk_cnt++;
         if (dut_vec !== mdl_vec) begin
            fail_cnt++;
            $display("FAIL rise_only_model n=%0d got=%h expected=%h", n, dut_vec, mdl_vec);
         end
      end
      chk_cnt++;
      if ({bus_r.EVT_PEND, bus_r.IRQ, bus_b.EVT_PEND, bus_r.DB_OUT[5]} !== {8'h00, 1'b0, 8'h20, 1'b0}) begin
         fail_cnt++;
         $display("FAIL rise_only_fall got r_pend=%h r_irq=%b b_pend=%h db5=%b expected 00 0 20 0",
                  bus_r.EVT_PEND, bus_r.IRQ, bus_b.EVT_PEND, bus_r.DB_OUT[5]);
      end
   endtask

   task automatic test_reset_mid();
      restart(8'h0F);
      for (int n = 1; n <= 8; n++) tick();
      raw_drv[7] = 1'b1;
      for (int n = 1; n <= 4; n++) tick();
      #2 nSRSTIN = 1'b0;
      #1;
      chk_cnt++;
      if (dut_vec !== 50'h0) begin
         fail_cnt++;
         $display("FAIL reset_mid_async got=%h expected=%h", dut_vec, 50'h0);
      end
      @(negedge CLKIN);
      model_reset();
      nSRSTIN = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         tick();
         chk_cnt++;
         if ({bus_b.DB_OUT, bus_b.RISE_PULSE} !== {(n >= 6) ? 8'h8F : 8'h00, (n == 6) ? 8'h8F : 8'h00}) begin
            fail_cnt++;
            $display("FAIL reset_mid_restart n=%0d got db=%h rise=%h", n, bus_b.DB_OUT, bus_b.RISE_PULSE);
         end
      end
   endtask

   task automatic test_random();
      int pulses = 0;
      restart(8'($urandom));
      for (int n = 0; n < 4000; n++) begin
         for (int ch = 0; ch < N_CH; ch++)
            if ($urandom_range(0, 5) == 0) raw_drv[ch] = ~raw_drv[ch];
         clr_drv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         tick();
         pulses += $countones(bus_b.RISE_PULSE | bus_b.FALL_PULSE);
         chk_cnt++;
         if (dut_vec !== mdl_vec) begin
            fail_cnt++;
            $display("FAIL random n=%0d raw=%h got=%h expected=%h", n, raw_drv, dut_vec, mdl_vec);
         end
      end
      chk_cnt++;
      if (pulses == 0) begin
         fail_cnt++;
         $display("FAIL random_activity got pulses=0 expected nonzero");
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_clear_race();
      test_rise_only();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
      $finish;
   end
endmodule
